// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester byte-wide memory arbiter.
//   arb_state_t : FSM states (IDLE, BYTE0, BYTE1, ACK)
//   req_id_t    : requester identifier (0 or 1)
//   MAX_WAIT    : largest supported WAIT_CYCLES value
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

    localparam int MAX_WAIT = 7;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker, purely combinational.
//   req[1:0]   : request bits, bit N for requester N
//   last_grant : requester granted most recently
//   grant      : chosen requester; only meaningful when |req
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    grant
);

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // Tie: the requester that did not win last time goes first.
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single 8-bit external memory port.
// 16-bit transfers are split into two little-endian byte phases.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   reqN_read_en / reqN_write_en : request strobes (N = 0,1); both set = write
//   reqN_dbl_byte_en             : 1 = 16-bit transfer, 0 = 8-bit
//   reqN_addr, reqN_wdata        : byte address, write data
//   reqN_ack, reqN_rdata         : completion pulse and read data
//   mem_addr, mem_wdata, mem_wr  : external byte port outputs
//   mem_rdata                    : external read byte
//   busy                         : 1 whenever the FSM is not IDLE
//   dbg_state                    : current FSM state, for observation
//
// Handshake: a requester holds read_en/write_en high with stable
// addr/wdata until it sees its own ack pulse. The request is captured on
// the grant edge and later input changes are ignored; ack is high for
// exactly one cycle and rdata is only valid in that cycle. A requester
// that keeps its enable high through ack is treated as a new request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_read_en,
    input  logic        req0_write_en,
    input  logic        req0_dbl_byte_en,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ack,
    output logic [15:0] req0_rdata,
    input  logic        req1_read_en,
    input  logic        req1_write_en,
    input  logic        req1_dbl_byte_en,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ack,
    output logic [15:0] req1_rdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    arb_state_t  state;
    arb_state_t  next_state;
    logic [2:0]  wait_cnt;
    req_id_t     last_grant;
    req_id_t     cur_id;
    req_id_t     pick;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_dbl;
    logic        lat_write;
    logic [15:0] rdata_q;
    logic [1:0]  req_vec;
    logic        phase_done;

    assign req_vec[0] = req0_read_en | req0_write_en;
    assign req_vec[1] = req1_read_en | req1_write_en;
    assign phase_done = (wait_cnt == WAIT_LAST);

    mem_arb_rr u_rr (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req_vec) next_state = BYTE0;
            BYTE0:   if (phase_done) next_state = lat_dbl ? BYTE1 : ACK;
            BYTE1:   if (phase_done) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture, wait counting and read-byte assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 3'd0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            lat_addr   <= 16'h0000;
            lat_wdata  <= 16'h0000;
            lat_dbl    <= 1'b0;
            lat_write  <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 3'd0;
                    if (|req_vec) begin
                        cur_id     <= pick;
                        last_grant <= pick;
                        rdata_q    <= 16'h0000;
                        if (pick) begin
                            lat_addr  <= req1_addr;
                            lat_wdata <= req1_wdata;
                            lat_dbl   <= req1_dbl_byte_en;
                            lat_write <= req1_write_en;
                        end else begin
                            lat_addr  <= req0_addr;
                            lat_wdata <= req0_wdata;
                            lat_dbl   <= req0_dbl_byte_en;
                            lat_write <= req0_write_en;
                        end
                    end
                end
                BYTE0, BYTE1: begin
                    if (phase_done) begin
                        wait_cnt <= 3'd0;
                        // Read data is taken on the last cycle of each phase,
                        // giving slow memory the full wait window.
                        if (!lat_write) begin
                            if (state == BYTE0) rdata_q[7:0]  <= mem_rdata;
                            else                rdata_q[15:8] <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: wait_cnt <= 3'd0;
            endcase
        end
    end

    // Outputs; forced to zero while rst is high so a reset aborts at once.
    always_comb begin
        req0_ack   = 1'b0;
        req1_ack   = 1'b0;
        req0_rdata = 16'h0000;
        req1_rdata = 16'h0000;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        mem_wr     = 1'b0;
        busy       = 1'b0;
        dbg_state  = 2'd0;
        if (!rst) begin
            busy      = (state != IDLE);
            dbg_state = state;
            case (state)
                BYTE0: begin
                    mem_addr  = lat_addr;
                    mem_wr    = lat_write;
                    mem_wdata = lat_write ? lat_wdata[7:0] : 8'h00;
                end
                BYTE1: begin
                    mem_addr  = lat_addr + 16'd1;
                    mem_wr    = lat_write;
                    mem_wdata = lat_write ? lat_wdata[15:8] : 8'h00;
                end
                ACK: begin
                    if (cur_id) begin
                        req1_ack   = 1'b1;
                        req1_rdata = rdata_q;
                    end else begin
                        req0_ack   = 1'b1;
                        req0_rdata = rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_read_en, req0_write_en, req0_dbl_byte_en;
    logic [15:0] req0_addr, req0_wdata, req0_rdata;
    logic        req0_ack;
    logic        req1_read_en, req1_write_en, req1_dbl_byte_en;
    logic [15:0] req1_addr, req1_wdata, req1_rdata;
    logic        req1_ack;
    logic [7:0]  mem_rdata, mem_wdata;
    logic [15:0] mem_addr;
    logic        mem_wr, busy;
    logic [1:0]  dbg_state;

    // Second instance with WAIT_CYCLES = 0
    logic        z_req0_read_en, z_req0_write_en, z_req0_dbl_byte_en;
    logic [15:0] z_req0_addr, z_req0_wdata, z_req0_rdata;
    logic        z_req0_ack;
    logic        z_req1_read_en, z_req1_write_en, z_req1_dbl_byte_en;
    logic [15:0] z_req1_addr, z_req1_wdata, z_req1_rdata;
    logic        z_req1_ack;
    logic [7:0]  z_mem_rdata, z_mem_wdata;
    logic [15:0] z_mem_addr;
    logic        z_mem_wr, z_busy;
    logic [1:0]  z_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    function automatic logic [7:0] rd_byte(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h0100: return 8'h11;
            16'h0200: return 8'h22;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] z_rd_byte(input logic [15:0] a);
        case (a)
            16'h0500: return 8'h34;
            16'h0501: return 8'h12;
            default:  return 8'h00;
        endcase
    endfunction

    assign mem_rdata   = rd_byte(mem_addr);
    assign z_mem_rdata = z_rd_byte(z_mem_addr);

    mem_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_read_en(req0_read_en), .req0_write_en(req0_write_en),
        .req0_dbl_byte_en(req0_dbl_byte_en), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
        .req1_read_en(req1_read_en), .req1_write_en(req1_write_en),
        .req1_dbl_byte_en(req1_dbl_byte_en), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .busy(busy), .dbg_state(dbg_state)
    );

    mem_arbiter #(.WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst),
        .req0_read_en(z_req0_read_en), .req0_write_en(z_req0_write_en),
        .req0_dbl_byte_en(z_req0_dbl_byte_en), .req0_addr(z_req0_addr),
        .req0_wdata(z_req0_wdata), .req0_ack(z_req0_ack), .req0_rdata(z_req0_rdata),
        .req1_read_en(z_req1_read_en), .req1_write_en(z_req1_write_en),
        .req1_dbl_byte_en(z_req1_dbl_byte_en), .req1_addr(z_req1_addr),
        .req1_wdata(z_req1_wdata), .req1_ack(z_req1_ack), .req1_rdata(z_req1_rdata),
        .mem_rdata(z_mem_rdata), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_wr(z_mem_wr), .busy(z_busy), .dbg_state(z_dbg_state)
    );

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_read_en = 0; req0_write_en = 0; req0_dbl_byte_en = 0;
        req1_read_en = 0; req1_write_en = 0; req1_dbl_byte_en = 0;
        z_req0_read_en = 0; z_req0_write_en = 0; z_req0_dbl_byte_en = 0;
        z_req1_read_en = 0; z_req1_write_en = 0; z_req1_dbl_byte_en = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        req0_addr = 16'h0; req0_wdata = 16'h0; req1_addr = 16'h0; req1_wdata = 16'h0;
        z_req0_addr = 16'h0; z_req0_wdata = 16'h0; z_req1_addr = 16'h0; z_req1_wdata = 16'h0;
        rst = 1'b1;
        #1;
        tick(); tick();

        // Reset: all outputs zero while rst high and afterwards
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wr", {15'd0, mem_wr}, 16'd0);
        chk("rst_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        #1;
        chk("post_rst_busy", {15'd0, busy}, 16'd0);
        chk("post_rst_acks", {14'd0, req1_ack, req0_ack}, 16'd0);
        chk("post_rst_rdata0", req0_rdata, 16'h0000);

        // req0 8-bit read at 0x1234, WAIT_CYCLES=1
        req0_read_en = 1; req0_addr = 16'h1234;
        tick();
        req0_read_en = 0;
        chk("rd8_addr_c1", mem_addr, 16'h1234);
        chk("rd8_busy_c1", {15'd0, busy}, 16'd1);
        chk("rd8_wr_c1", {15'd0, mem_wr}, 16'd0);
        tick();
        chk("rd8_addr_c2", mem_addr, 16'h1234);
        chk("rd8_ack_c2", {15'd0, req0_ack}, 16'd0);
        tick();
        chk("rd8_ack_c3", {14'd0, req1_ack, req0_ack}, 16'b01);
        chk("rd8_rdata", req0_rdata, 16'h00A5);
        chk("rd8_addr_ack", mem_addr, 16'h0000);
        tick();
        chk("rd8_ack_gone", {15'd0, req0_ack}, 16'd0);
        chk("rd8_rdata_gone", req0_rdata, 16'h0000);
        chk("rd8_idle_busy", {15'd0, busy}, 16'd0);

        // req1 16-bit write 0xBEEF at 0xFFFF (address wrap)
        req1_write_en = 1; req1_dbl_byte_en = 1; req1_addr = 16'hFFFF; req1_wdata = 16'hBEEF;
        tick();
        req1_write_en = 0;
        for (int c = 0; c < 2; c++) begin
            chk("wr16_b0_addr", mem_addr, 16'hFFFF);
            chk("wr16_b0_data", {8'd0, mem_wdata}, 16'h00EF);
            chk("wr16_b0_wr", {15'd0, mem_wr}, 16'd1);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            chk("wr16_b1_addr", mem_addr, 16'h0000);
            chk("wr16_b1_data", {8'd0, mem_wdata}, 16'h00BE);
            chk("wr16_b1_wr", {15'd0, mem_wr}, 16'd1);
            tick();
        end
        chk("wr16_ack", {14'd0, req1_ack, req0_ack}, 16'b10);
        chk("wr16_ack_wr", {15'd0, mem_wr}, 16'd0);
        tick();
        chk("wr16_ack_single", {14'd0, req1_ack, req0_ack}, 16'b00);

        // Both requesters read continuously: grants alternate 0,1,0,1
        req0_read_en = 1; req0_addr = 16'h0100; req0_dbl_byte_en = 0;
        req1_read_en = 1; req1_addr = 16'h0200; req1_dbl_byte_en = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_no_ack_b0", {14'd0, req1_ack, req0_ack}, 16'b00);
            tick();
            tick();
            if (k % 2 == 0) begin
                chk("rr_ack_req0", {14'd0, req1_ack, req0_ack}, 16'b01);
                chk("rr_rdata0", req0_rdata, 16'h0011);
                chk("rr_rdata1_zero", req1_rdata, 16'h0000);
            end else begin
                chk("rr_ack_req1", {14'd0, req1_ack, req0_ack}, 16'b10);
                chk("rr_rdata1", req1_rdata, 16'h0022);
                chk("rr_rdata0_zero", req0_rdata, 16'h0000);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Mid-transfer input changes ignored; read+write treated as write
        req0_read_en = 1; req0_write_en = 1; req0_dbl_byte_en = 1;
        req0_addr = 16'h2000; req0_wdata = 16'h5678;
        tick();
        req0_read_en = 0; req0_write_en = 0; req0_dbl_byte_en = 0;
        req0_addr = 16'h3000; req0_wdata = 16'h9999;
        chk("mid_b0_addr", mem_addr, 16'h2000);
        chk("mid_b0_data", {8'd0, mem_wdata}, 16'h0078);
        chk("mid_b0_wr", {15'd0, mem_wr}, 16'd1);
        tick(); tick();
        chk("mid_b1_addr", mem_addr, 16'h2001);
        chk("mid_b1_data", {8'd0, mem_wdata}, 16'h0056);
        tick(); tick();
        chk("mid_ack", {14'd0, req1_ack, req0_ack}, 16'b01);
        tick();

        // Reset during BYTE1 of a 16-bit write
        req1_write_en = 1; req1_dbl_byte_en = 1; req1_addr = 16'h4000; req1_wdata = 16'hCAFE;
        tick();
        req1_write_en = 0; req1_dbl_byte_en = 0;
        tick(); tick();
        chk("abort_b1_addr", mem_addr, 16'h4001);
        chk("abort_b1_wr", {15'd0, mem_wr}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_wr_off", {15'd0, mem_wr}, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_no_ack", {14'd0, req1_ack, req0_ack}, 16'b00);
        tick();
        chk("abort_no_ack2", {14'd0, req1_ack, req0_ack}, 16'b00);
        req0_read_en = 1; req0_addr = 16'h0100;
        req1_read_en = 1; req1_addr = 16'h0200;
        tick();
        idle_inputs();
        tick(); tick();
        chk("abort_tie_req0", {14'd0, req1_ack, req0_ack}, 16'b01);
        chk("abort_tie_rdata", req0_rdata, 16'h0011);
        tick();

        // WAIT_CYCLES=0 instance: 16-bit read of 0x34 then 0x12
        z_req0_read_en = 1; z_req0_dbl_byte_en = 1; z_req0_addr = 16'h0500;
        tick();
        z_req0_read_en = 0; z_req0_dbl_byte_en = 0;
        chk("w0_b0_addr", z_mem_addr, 16'h0500);
        tick();
        chk("w0_b1_addr", z_mem_addr, 16'h0501);
        tick();
        chk("w0_ack", {14'd0, z_req1_ack, z_req0_ack}, 16'b01);
        chk("w0_rdata", z_req0_rdata, 16'h1234);
        tick();
        chk("w0_ack_gone", {15'd0, z_req0_ack}, 16'd0);
        chk("w0_rdata_gone", z_req0_rdata, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
